glitch_sweep_ctrl: RTL

Sequencer that drives the combinational glitch circuit through every input pattern, from 0 to 2**X_WIDTH-1.
- For each pattern, waits a programmable settle window and counts output toggles during it.
- Per pattern, reports the settled outputs and a per-bit glitch flag over a valid/ready stream.
- Sits between the glitch datapath (drives x, observes y) and a test/status consumer; replaces hand-written stimulus sequences.

---
 rtl/glitch_ctrl_pkg.sv | 16 +
 rtl/glitch_toggle_cnt.sv | 30 +++
 rtl/glitch_sweep_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/glitch_ctrl_pkg.sv
// Shared constants for the glitch-circuit sweep sequencer: FSM encoding,
// toggle saturation point and settle counter width.
package glitch_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_REPORT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int X_WIDTH_DEF = 3;
  localparam int N_PATTERNS  = 2**X_WIDTH_DEF;
  localparam int TOG_SAT     = 2;
  localparam int SETTLE_W    = $clog2(256);

endpackage

// File: rtl/glitch_toggle_cnt.sv
// Per-bit saturating toggle counter; hit reflects the count including the
// current cycle's increment so the last settle cycle is not lost.
module glitch_toggle_cnt
  import glitch_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = 2'd0;
    else if (en && (cnt < 2'(TOG_SAT)))
      cnt_nxt = cnt + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 2'd0;
    else     cnt <= cnt_nxt;
  end

  assign hit = (cnt_nxt >= 2'(TOG_SAT));

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Walks the glitch circuit through every input pattern, watches y for a
// settle window per pattern and streams out settled value plus glitch flags.
module glitch_sweep_ctrl
  import glitch_ctrl_pkg::*;
#(
  parameter int X_WIDTH       = 3,
  parameter int Y_WIDTH       = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [X_WIDTH-1:0]    x,
  input  logic [Y_WIDTH-1:0]    y,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [X_WIDTH-1:0]    res_pattern,
  output logic [Y_WIDTH-1:0]    res_y,
  output logic [Y_WIDTH-1:0]    res_glitch,
  output logic [2**X_WIDTH-1:0] glitch_mask,
  output logic [X_WIDTH:0]      glitch_count
);

  localparam int NP = 2**X_WIDTH;

  logic [2:0]          state;
  logic [X_WIDTH-1:0]  pat;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [Y_WIDTH-1:0]  y_q, y_last, tog_en, tog_hit;
  logic                tog_clr;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign tog_clr = (state == ST_APPLY);

  for (genvar gi = 0; gi < Y_WIDTH; gi++) begin : g_tog
    assign tog_en[gi] = (state == ST_SETTLE) && (y_q[gi] != y_last[gi]);
    glitch_toggle_cnt u_tog (
      .clk (clk),
      .rst (rst),
      .clr (tog_clr),
      .en  (tog_en[gi]),
      .hit (tog_hit[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pat          <= '0;
      settle_cnt   <= '0;
      x            <= '0;
      y_q          <= '0;
      y_last       <= '0;
      res_valid    <= 1'b0;
      res_pattern  <= '0;
      res_y        <= '0;
      res_glitch   <= '0;
      glitch_mask  <= '0;
      glitch_count <= '0;
    end else begin
      y_q <= y;
      case (state)
        ST_IDLE: if (start) begin
          state        <= ST_APPLY;
          pat          <= '0;
          glitch_mask  <= '0;
          glitch_count <= '0;
        end
        ST_APPLY: begin
          // y_last taken here so a toggle straddling the x change still counts
          x          <= pat;
          y_last     <= y_q;
          settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          y_last <= y_q;
          if (settle_cnt == '0) begin
            res_y       <= y_q;
            res_glitch  <= tog_hit;
            res_pattern <= pat;
            res_valid   <= 1'b1;
            state       <= ST_REPORT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_REPORT: if (res_ready) begin
          res_valid        <= 1'b0;
          glitch_mask[pat] <= |res_glitch;
          if ((|res_glitch) && (glitch_count < (X_WIDTH+1)'(NP)))
            glitch_count <= glitch_count + 1'b1;
          if (pat == X_WIDTH'(NP - 1)) begin
            state <= ST_DONE;
          end else begin
            pat   <= pat + 1'b1;
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          x     <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
